vector_exec_sequencer: RTL and testbench
========================================

VECTOR_EXEC_SEQUENCER -- requirements
Module: vector_exec_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 24, element width in bits.
REQ-002 SHALL have parameter VECTOR_WIDTH, default 8, number of elements per vector (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start_valid  input  1  request to run one vector op.
REQ-006 SHALL have port start_ready  output  1  sequencer can accept a request.
REQ-007 SHALL have port op  input  3  ALU control code, forwarded unchanged to the ALU.
REQ-008 SHALL have ports A, B  input  [VECTOR_WIDTH-1:0][WIDTH-1:0]  operand vectors.
REQ-009 SHALL have port flush  input  1  abort current operation.
REQ-010 SHALL have ports alu_a, alu_b  output  WIDTH  element operands to the shared scalar ALU.
REQ-011 SHALL have port alu_ctrl  output  3  ALU control code; port alu_req  output  1  ALU slot in use.
REQ-012 SHALL have ports alu_result  input  WIDTH and alu_n, alu_z, alu_v, alu_c  input  1  combinational ALU response.
REQ-013 SHALL have port result  output  [VECTOR_WIDTH-1:0][WIDTH-1:0]  assembled vector result.
REQ-014 SHALL have ports N, Z, V, C  output  1  vector flags; port busy  output  1; port done  output  1.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE.
REQ-016 IDLE: start_ready = !flush; on start_valid && start_ready SHALL latch A, B, op, clear index to 0, go to RUN.
REQ-017 RUN: SHALL drive alu_a = A_q[idx], alu_b = B_q[idx], alu_ctrl = op_q, alu_req = 1, and capture alu_result into result[idx] at the clock edge.
REQ-018 RUN: index SHALL increment by 1 per cycle; after capturing element VECTOR_WIDTH-1 SHALL go to DONE (no wrap beyond VECTOR_WIDTH-1).
REQ-019 DONE: done = 1 for exactly one cycle, then IDLE; result and flags SHALL hold until the next accepted start.
REQ-020 Latency SHALL be: start accepted in cycle 0, elements captured in cycles 1..VECTOR_WIDTH, done high in cycle VECTOR_WIDTH+1.
REQ-021 busy SHALL be 1 in RUN and DONE, 0 in IDLE; start_ready SHALL be 0 whenever busy.
REQ-022 Outside RUN: alu_req = 0, alu_a = alu_b = 0, alu_ctrl = 0.
REQ-023 flush in RUN SHALL return to IDLE at the next edge without asserting done; elements already captured SHALL be kept; flags are not updated.
REQ-024 flush in DONE SHALL be ignored (done still pulses); flush with start_valid in IDLE SHALL reject the start.
REQ-025 start_valid held high across DONE SHALL be accepted in the following IDLE cycle; back-to-back throughput is one op per VECTOR_WIDTH+2 cycles.

Reset
REQ-026 While rst_n = 0: state = IDLE, index = 0, result = 0, N = Z = V = C = 0, done = 0, busy = 0, alu_req = 0; start_ready = 1 from the first edge after release.

Configuration
REQ-027 With VSEQ_FLAG_ACCUM_EN defined, flags SHALL accumulate across elements: Z = AND of all alu_z, N/V/C = OR of all alu_n/alu_v/alu_c, registered on entry to DONE.
REQ-028 Without VSEQ_FLAG_ACCUM_EN, N/Z/V/C SHALL be the alu flags of element VECTOR_WIDTH-1 only, registered at its capture.

Structure
REQ-029 Package vseq_pkg SHALL hold the state enum (IDLE, RUN, DONE) and ALU op-code constants (ADD = 3'b000, SUB = 3'b001).
REQ-030 Flag accumulation SHALL live in sub-module vseq_flag_accum (clear/update/hold); index counter and FSM in the top module.

Verification
REQ-031 Reset mid-RUN (rst_n low at element 3) -> next cycle state IDLE, result all 0, busy 0, no done.
REQ-032 ADD, A[i] = i, B[i] = 10 -> result[i] = i+10, done in cycle 9 (VECTOR_WIDTH = 8), alu_req high exactly cycles 1..8.
REQ-033 SUB, A[i] = 5, B[i] = 5 -> result all 0; Z = 1 in both configurations; with VSEQ_FLAG_ACCUM_EN and A[2] = 6, Z = 0.
REQ-034 flush at element 4 of ADD -> IDLE next cycle, done never asserted, result[0..3] updated, result[4..7] unchanged.
REQ-035 start_valid held high for 30 cycles -> exactly 3 accepted ops, done pulses at cycles 9, 19, 29, start_ready 0 while busy.
REQ-036 flush and start_valid both high in IDLE -> start not accepted, busy stays 0; dropping flush next cycle -> accepted.

Source files
------------

// File: rtl/vseq_pkg.sv
// vseq_pkg: sequencer state encoding and the ALU op codes shared by the
// vector execution sequencer and anything that drives it.
package vseq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } vseq_state_t;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;

endpackage

// File: rtl/vseq_flag_accum.sv
// vseq_flag_accum: produces the vector N/Z/V/C flags from the per-element ALU flags.
// Build macro VSEQ_FLAG_ACCUM_EN: flags cover every element; otherwise only the last element.
module vseq_flag_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic update,
    input  logic last,
    input  logic alu_n,
    input  logic alu_z,
    input  logic alu_v,
    input  logic alu_c,
    output logic n,
    output logic z,
    output logic v,
    output logic c
);

`ifdef VSEQ_FLAG_ACCUM_EN
    logic acc_n, acc_z, acc_v, acc_c;
    logic nxt_n, nxt_z, nxt_v, nxt_c;

    always_comb begin
        nxt_n = acc_n | alu_n;
        nxt_z = acc_z & alu_z;
        nxt_v = acc_v | alu_v;
        nxt_c = acc_c | alu_c;
    end

    // Outputs only move when the last element lands, so a flushed op leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_n <= 1'b0;
            acc_z <= 1'b1;
            acc_v <= 1'b0;
            acc_c <= 1'b0;
            n     <= 1'b0;
            z     <= 1'b0;
            v     <= 1'b0;
            c     <= 1'b0;
        end else if (clear) begin
            acc_n <= 1'b0;
            acc_z <= 1'b1;
            acc_v <= 1'b0;
            acc_c <= 1'b0;
        end else if (update) begin
            acc_n <= nxt_n;
            acc_z <= nxt_z;
            acc_v <= nxt_v;
            acc_c <= nxt_c;
            if (last) begin
                n <= nxt_n;
                z <= nxt_z;
                v <= nxt_v;
                c <= nxt_c;
            end
        end
    end
`else
    logic unused_clear;
    assign unused_clear = clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n <= 1'b0;
            z <= 1'b0;
            v <= 1'b0;
            c <= 1'b0;
        end else if (update && last) begin
            n <= alu_n;
            z <= alu_z;
            v <= alu_v;
            c <= alu_c;
        end
    end
`endif

endmodule

// File: rtl/vector_exec_sequencer.sv
// vector_exec_sequencer: walks one shared scalar ALU across VECTOR_WIDTH element pairs,
// one element per cycle, and assembles the vector result (flags via VSEQ_FLAG_ACCUM_EN option).
module vector_exec_sequencer
    import vseq_pkg::*;
#(
    parameter int WIDTH        = 24,
    parameter int VECTOR_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start_valid,
    output logic                               start_ready,
    input  logic [2:0]                         op,
    input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] A,
    input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] B,
    input  logic                               flush,
    output logic [WIDTH-1:0]                   alu_a,
    output logic [WIDTH-1:0]                   alu_b,
    output logic [2:0]                         alu_ctrl,
    output logic                               alu_req,
    input  logic [WIDTH-1:0]                   alu_result,
    input  logic                               alu_n,
    input  logic                               alu_z,
    input  logic                               alu_v,
    input  logic                               alu_c,
    output logic [VECTOR_WIDTH-1:0][WIDTH-1:0] result,
    output logic                               N,
    output logic                               Z,
    output logic                               V,
    output logic                               C,
    output logic                               busy,
    output logic                               done
);

    localparam int              IDXW     = $clog2(VECTOR_WIDTH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(VECTOR_WIDTH - 1);

    vseq_state_t                        state_q, state_d;
    logic [IDXW-1:0]                    idx_q;
    logic [VECTOR_WIDTH-1:0][WIDTH-1:0] a_q, b_q;
    logic [2:0]                         op_q;
    logic                               accept, capture, idx_last;

    assign idx_last = (idx_q == LAST_IDX);

    // A flush during RUN wins over capturing the current element.
    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        alu_req     = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_ctrl    = '0;
        accept      = 1'b0;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = !flush;
                accept      = start_valid && !flush;
                if (accept) state_d = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                alu_req  = 1'b1;
                alu_a    = a_q[idx_q];
                alu_b    = b_q[idx_q];
                alu_ctrl = op_q;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    capture = 1'b1;
                    if (idx_last) state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            result  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= op;
                idx_q <= '0;
            end else if (capture) begin
                result[idx_q] <= alu_result;
                idx_q         <= idx_last ? '0 : idx_q + IDXW'(1);
            end
        end
    end

    vseq_flag_accum u_flag_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .update (capture),
        .last   (idx_last),
        .alu_n  (alu_n),
        .alu_z  (alu_z),
        .alu_v  (alu_v),
        .alu_c  (alu_c),
        .n      (N),
        .z      (Z),
        .v      (V),
        .c      (C)
    );

endmodule

// File: tb/tb_vector_exec_sequencer.sv
// tb_vector_exec_sequencer: directed self-checking bench with a behavioural scalar ALU.
// Honours VSEQ_FLAG_ACCUM_EN for the flag expectations.
module tb_vector_exec_sequencer;
    import vseq_pkg::*;

    localparam int WIDTH = 24;
    localparam int VW    = 8;

    typedef logic [VW-1:0][WIDTH-1:0] vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic [2:0]       op;
    vec_t             a_in, b_in;
    logic             flush;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [2:0]       alu_ctrl;
    logic             alu_req;
    logic             alu_n, alu_z, alu_v, alu_c;
    logic [WIDTH:0]   alu_wide;
    vec_t             result;
    logic             N, Z, V, C;
    logic             busy, done;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    vector_exec_sequencer #(.WIDTH(WIDTH), .VECTOR_WIDTH(VW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op          (op),
        .A           (a_in),
        .B           (b_in),
        .flush       (flush),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_req     (alu_req),
        .alu_result  (alu_result),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .alu_v       (alu_v),
        .alu_c       (alu_c),
        .result      (result),
        .N           (N),
        .Z           (Z),
        .V           (V),
        .C           (C),
        .busy        (busy),
        .done        (done)
    );

    // Scalar ALU: C is carry out for ADD and borrow for SUB.
    always_comb begin
        alu_v = 1'b0;
        if (alu_ctrl == SUB) begin
            alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
            alu_v    = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_wide[WIDTH-1] != alu_a[WIDTH-1]);
        end else begin
            alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            alu_v    = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_wide[WIDTH-1] != alu_a[WIDTH-1]);
        end
        alu_result = alu_wide[WIDTH-1:0];
        alu_c      = alu_wide[WIDTH];
        alu_n      = alu_wide[WIDTH-1];
        alu_z      = (alu_wide[WIDTH-1:0] == '0);
    end

    function automatic vec_t ramp(input int base, input int stepv);
        vec_t v;
        for (int i = 0; i < VW; i++) v[i] = WIDTH'(base + i * stepv);
        return v;
    endfunction

    function automatic vec_t fill(input int value);
        vec_t v;
        for (int i = 0; i < VW; i++) v[i] = WIDTH'(value);
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] code, input logic fl);
        start_valid = valid;
        op          = code;
        flush       = fl;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one op to completion; the cycle-1 and cycle-(VW+1) samples check alu_ctrl.
    task automatic runOp(input string tag, input logic [2:0] code);
        int dones = 0;
        nextCycle();
        applyStimulus(1'b1, code, 1'b0);
        for (int c = 1; c <= VW + 2; c++) begin
            nextCycle();
            applyStimulus(1'b0, code, 1'b0);
            #1;
            if (done) dones++;
            if (c == 1)      checkOutput({tag, " alu_ctrl run"}, alu_ctrl, code);
            if (c == VW + 1) checkOutput({tag, " alu_ctrl done"}, alu_ctrl, 3'b000);
        end
        checkOutput({tag, " done count"}, dones, 1);
        checkOutput({tag, " busy after"}, busy, 0);
    endtask

    initial begin
        int dones;
        int accepts;
        logic acc_en;
`ifdef VSEQ_FLAG_ACCUM_EN
        acc_en = 1'b1;
`else
        acc_en = 1'b0;
`endif
        a_in = '0;
        b_in = '0;
        applyStimulus(1'b0, ADD, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset alu_req", alu_req, 0);
        checkOutput("reset result zero", (result == '0), 1);
        checkOutput("reset flags", {N, Z, V, C}, 4'b0000);
        #9 rst_n = 1'b1;
        nextCycle();
        #1;
        checkOutput("post-reset start_ready", start_ready, 1);

        // ADD ramp + 10; A is scrambled after acceptance and flush is raised during DONE.
        nextCycle();
        a_in = ramp(0, 1);
        b_in = fill(10);
        applyStimulus(1'b1, ADD, 1'b0);
        #1;
        checkOutput("add start_ready c0", start_ready, 1);
        for (int c = 1; c <= 10; c++) begin
            nextCycle();
            applyStimulus(1'b0, ADD, (c == 9));
            a_in = fill(24'h5A5A5A);
            #1;
            checkOutput($sformatf("add alu_req c%0d", c), alu_req, (c <= 8));
            checkOutput($sformatf("add done c%0d", c), done, (c == 9));
            checkOutput($sformatf("add busy c%0d", c), busy, (c <= 9));
            checkOutput($sformatf("add start_ready c%0d", c), start_ready, (c == 10));
            checkOutput($sformatf("add alu_a c%0d", c), alu_a, (c <= 8) ? c - 1 : 0);
            checkOutput($sformatf("add alu_b c%0d", c), alu_b, (c <= 8) ? 10 : 0);
        end
        applyStimulus(1'b0, ADD, 1'b0);
        for (int i = 0; i < VW; i++)
            checkOutput($sformatf("add result[%0d]", i), result[i], i + 10);
        checkOutput("add flags", {N, Z, V, C}, 4'b0000);

        // SUB equal operands: all zero, Z set either way.
        a_in = fill(5);
        b_in = fill(5);
        runOp("sub eq", SUB);
        checkOutput("sub eq result zero", (result == '0), 1);
        checkOutput("sub eq flags", {N, Z, V, C}, 4'b0100);

        // Element 2 non-zero: only accumulation sees it.
        a_in[2] = 24'd6;
        runOp("sub a2", SUB);
        checkOutput("sub a2 result[2]", result[2], 1);
        checkOutput("sub a2 result[7]", result[7], 0);
        checkOutput("sub a2 flags", {N, Z, V, C}, acc_en ? 4'b0000 : 4'b0100);

        // Element 0 borrows, last element is zero.
        a_in = fill(5);
        a_in[0] = 24'd4;
        runOp("sub a0", SUB);
        checkOutput("sub a0 result[0]", result[0], 24'hFFFFFF);
        checkOutput("sub a0 flags", {N, Z, V, C}, acc_en ? 4'b1001 : 4'b0100);

        // Reference op P[i] = i - 20, then an ADD flushed at element 4.
        a_in = ramp(0, 1);
        b_in = fill(20);
        runOp("pre", SUB);
        checkOutput("pre flags", {N, Z, V, C}, 4'b1001);
        b_in = fill(10);
        dones = 0;
        nextCycle();
        applyStimulus(1'b1, ADD, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            nextCycle();
            applyStimulus(1'b0, ADD, (c == 5));
            #1;
            if (done) dones++;
            if (c <= 5) checkOutput($sformatf("flush start_ready c%0d", c), start_ready, (c == 5) ? 0 : 0);
            if (c == 6) checkOutput("flush busy c6", busy, 0);
        end
        checkOutput("flush done count", dones, 0);
        for (int i = 0; i < VW; i++)
            checkOutput($sformatf("flush result[%0d]", i), result[i],
                        (i < 4) ? i + 10 : 24'hFFFFEC + i);
        checkOutput("flush flags", {N, Z, V, C}, 4'b1001);

        // Asynchronous reset at element 3.
        dones = 0;
        nextCycle();
        applyStimulus(1'b1, ADD, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            nextCycle();
            applyStimulus(1'b0, ADD, 1'b0);
            #1;
            if (done) dones++;
        end
        checkOutput("rst mid busy before", busy, 1);
        rst_n = 1'b0;
        nextCycle();
        #1;
        checkOutput("rst mid busy", busy, 0);
        checkOutput("rst mid alu_req", alu_req, 0);
        checkOutput("rst mid result zero", (result == '0), 1);
        checkOutput("rst mid flags", {N, Z, V, C}, 4'b0000);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            nextCycle();
            #1;
            if (done) dones++;
        end
        checkOutput("rst mid done count", dones, 0);
        checkOutput("rst mid start_ready", start_ready, 1);

        // start_valid held for 30 cycles: accepts at 0/10/20, done at 9/19/29.
        a_in = ramp(1, 2);
        b_in = fill(3);
        dones   = 0;
        accepts = 0;
        for (int c = 0; c < 30; c++) begin
            nextCycle();
            applyStimulus(1'b1, ADD, 1'b0);
            #1;
            if (done) dones++;
            if (start_valid && start_ready) accepts++;
            checkOutput($sformatf("b2b done c%0d", c), done, ((c % 10) == 9));
            checkOutput($sformatf("b2b start_ready c%0d", c), start_ready, ((c % 10) == 0));
        end
        applyStimulus(1'b0, ADD, 1'b0);
        checkOutput("b2b accepts", accepts, 3);
        checkOutput("b2b done count", dones, 3);
        nextCycle();
        #1;
        checkOutput("b2b idle busy", busy, 0);
        for (int i = 0; i < VW; i++)
            checkOutput($sformatf("b2b result[%0d]", i), result[i], 2 * i + 4);

        // flush blocks a start in IDLE; the retry without flush goes through.
        nextCycle();
        applyStimulus(1'b1, ADD, 1'b1);
        #1;
        checkOutput("fs start_ready", start_ready, 0);
        nextCycle();
        applyStimulus(1'b1, ADD, 1'b0);
        #1;
        checkOutput("fs busy rejected", busy, 0);
        checkOutput("fs start_ready retry", start_ready, 1);
        nextCycle();
        applyStimulus(1'b0, ADD, 1'b0);
        #1;
        checkOutput("fs busy accepted", busy, 1);
        dones = 0;
        for (int c = 2; c <= 10; c++) begin
            nextCycle();
            #1;
            if (done) dones++;
        end
        checkOutput("fs done count", dones, 1);
        checkOutput("fs busy after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
